// File: rtl/gf_red_seq.sv
// gf_red_seq: bit-serial reduction of a 2m-bit GF(2) polynomial A modulo a
// runtime-selected polynomial P of degree m (2 <= m <= DATA_WIDTH).
// One conditional-XOR stage is reused for m cycles per request.
//   clk, rst_n            : clock, synchronous active-low reset
//   in_valid / in_ready   : request handshake (operands sampled on acceptance)
//   polyn_grade           : degree m
//   polyn_red_in          : P, bit i = coefficient of x^i (bits above m ignored)
//   reduc_in              : A (bits at 2m and above ignored)
//   out_valid / out_ready : result handshake
//   out                   : A mod P, zero-extended above bit m-1
//   grade_err             : with out_valid, m was outside 2..DATA_WIDTH
module gf_red_seq #(
  parameter int DATA_WIDTH = 10
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [$clog2(DATA_WIDTH):0]  polyn_grade,
  input  logic [DATA_WIDTH:0]          polyn_red_in,
  input  logic [2*DATA_WIDTH-1:0]      reduc_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH-1:0]        out,
  output logic                         grade_err
);

  localparam int N  = DATA_WIDTH;
  localparam int GW = $clog2(DATA_WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [GW-1:0]    m_q, m_d;
  logic [N:0]       p_q, p_d;
  logic [2*N-1:0]   a_q, a_d;
  logic [N-1:0]     acc_q, acc_d;
  logic [GW-1:0]    cnt_q, cnt_d;
  logic [N-1:0]     out_q, out_d;
  logic             grade_err_q, grade_err_d;
  logic             rdy_q;

  logic [N:0]       mask_in, mask_run, x_m, t, t_sh, t_red;
  logic [2*N-1:0]   a_shift;
  logic [N-1:0]     acc_next;
  logic             grade_ok;

  // Bits [m-1:0] set.
  function automatic logic [N:0] low_mask(input logic [GW-1:0] m);
    logic [N:0] mk;
    mk = '0;
    for (int unsigned i = 0; i <= N; i++) begin
      if (i < 32'(m)) mk[i] = 1'b1;
    end
    return mk;
  endfunction

  always_comb begin
    state_d     = state_q;
    m_d         = m_q;
    p_d         = p_q;
    a_d         = a_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_d       = out_q;
    grade_err_d = grade_err_q;

    grade_ok = (polyn_grade >= GW'(2)) && (polyn_grade <= GW'(N));
    mask_in  = low_mask(polyn_grade);
    mask_run = low_mask(m_q);
    x_m      = {{N{1'b0}}, 1'b1} << polyn_grade;
    a_shift  = reduc_in >> polyn_grade;

    // acc is kept below degree m, so t has at most bit m set above m-1;
    // XOR with the stored P (bit m forced) clears it whenever it is set.
    t        = {acc_q, a_q[cnt_q - GW'(1)]};
    t_sh     = t >> m_q;
    t_red    = t_sh[0] ? (t ^ p_q) : t;
    acc_next = t_red[N-1:0] & mask_run[N-1:0];

    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          m_d = polyn_grade;
          p_d = (polyn_red_in & mask_in) | x_m;
          a_d = reduc_in;
          if (grade_ok) begin
            acc_d   = a_shift[N-1:0] & mask_in[N-1:0];
            cnt_d   = polyn_grade;
            state_d = RUN;
          end else begin
            out_d       = '0;
            grade_err_d = 1'b1;
            state_d     = DONE;
          end
        end
      end
      RUN: begin
        acc_d = acc_next;
        cnt_d = cnt_q - GW'(1);
        if (cnt_q == GW'(1)) begin
          out_d       = acc_next;
          grade_err_d = 1'b0;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      m_q         <= '0;
      p_q         <= '0;
      a_q         <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_q       <= '0;
      grade_err_q <= 1'b0;
      rdy_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      m_q         <= m_d;
      p_q         <= p_d;
      a_q         <= a_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      grade_err_q <= grade_err_d;
      rdy_q       <= 1'b1;
    end
  end

  // rdy_q holds in_ready low until the first edge out of reset.
  assign in_ready  = (state_q == IDLE) && rdy_q;
  assign out_valid = (state_q == DONE);
  assign out       = out_q;
  assign grade_err = grade_err_q;

endmodule

// File: tb/tb_gf_red_seq.sv
module tb_gf_red_seq;

  localparam int N  = 10;
  localparam int GW = 5;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [GW-1:0]   polyn_grade = '0;
  logic [N:0]      polyn_red_in = '0;
  logic [2*N-1:0]  reduc_in = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [N-1:0]    out;
  logic            grade_err;

  int checks = 0;
  int errors = 0;

  gf_red_seq #(.DATA_WIDTH(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .polyn_grade(polyn_grade), .polyn_red_in(polyn_red_in), .reduc_in(reduc_in),
    .out_valid(out_valid), .out_ready(out_ready), .out(out), .grade_err(grade_err)
  );

  always #5 clk = ~clk;

  // Polynomial long division over GF(2).
  function automatic logic [N-1:0] ref_mod(input int m, input logic [N:0] p, input logic [2*N-1:0] a);
    logic [2*N:0] r;
    logic [2*N:0] pp;
    r  = '0;
    pp = '0;
    for (int i = 0; i < 2 * m; i++) r[i] = a[i];
    for (int i = 0; i < m; i++) pp[i] = p[i];
    pp[m] = 1'b1;
    for (int i = 2 * m - 1; i >= m; i--)
      if (r[i]) r = r ^ (pp << (i - m));
    return r[N-1:0];
  endfunction

  // Present one request and return #1 after the accepting edge; operands are
  // then scrambled so any late sampling by the DUT shows up as a wrong result.
  task automatic send(input int m, input logic [N:0] p, input logic [2*N-1:0] a);
    int b;
    b = 0;
    @(negedge clk);
    while (!in_ready && b < 50) begin
      @(negedge clk);
      b++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout in_ready=%0b required 1", in_ready);
    end
    polyn_grade  = GW'(m);
    polyn_red_in = p;
    reduc_in     = a;
    in_valid     = 1'b1;
    @(posedge clk);
    #1;
    in_valid     = 1'b0;
    polyn_grade  = GW'($urandom);
    polyn_red_in = (N+1)'($urandom);
    reduc_in     = (2*N)'($urandom);
  endtask

  // Edges after the accepting edge until out_valid is seen (bounded).
  task automatic wait_out(output int lat);
    lat = 0;
    @(negedge clk);
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, grade_err} !== 3'b000 || out !== '0) begin
      errors++;
      $display("FAIL reset_outputs rdy=%0b vld=%0b err=%0b out=%h required 0 0 0 000",
               in_ready, out_valid, grade_err, out);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_rdy_early in_ready=%0b required 0", in_ready);
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_rdy_rise in_ready=%0b out_valid=%0b required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_vectors();
    int          tm [6] = '{4, 4, 8, 8, 10, 10};
    logic [N:0]  tp [6] = '{11'h013, 11'h013, 11'h11B, 11'h11B, 11'h409, 11'h409};
    logic [19:0] ta [6] = '{20'h00010, 20'h0007F, 20'h02B79, 20'hF2B79, 20'h00400, 20'hFFFFF};
    logic [N-1:0] te [6];
    int lat;
    te = '{10'h003, 10'h006, 10'h0C1, 10'h0C1, 10'h009, 10'h000};
    te[5] = ref_mod(10, 11'h409, 20'hFFFFF);
    for (int k = 0; k < 6; k++) begin
      send(tm[k], tp[k], ta[k]);
      wait_out(lat);
      checks++;
      if (lat !== tm[k]) begin
        errors++;
        $display("FAIL vec%0d_latency got=%0d required %0d", k, lat, tm[k]);
      end
      checks++;
      if (out !== te[k] || grade_err !== 1'b0) begin
        errors++;
        $display("FAIL vec%0d_result out=%h err=%0b required %h 0", k, out, grade_err, te[k]);
      end
      handshake();
    end
  endtask

  task automatic test_random();
    int m, lat;
    logic [N:0] p;
    logic [2*N-1:0] a;
    logic [N-1:0] exp;
    for (int k = 0; k < 40; k++) begin
      m   = int'($urandom_range(2, N));
      p   = (N+1)'($urandom);
      a   = (2*N)'($urandom);
      exp = ref_mod(m, p, a);
      send(m, p, a);
      wait_out(lat);
      checks++;
      if (lat !== m || out !== exp || grade_err !== 1'b0) begin
        errors++;
        $display("FAIL rand%0d m=%0d p=%h a=%h lat=%0d out=%h err=%0b required lat=%0d out=%h err=0",
                 k, m, p, a, lat, out, grade_err, m, exp);
      end
      handshake();
    end
  endtask

  task automatic test_back_to_back();
    int lat, bad, gap;
    send(4, 11'h013, 20'h0007F);
    // Second request held pending throughout the first operation.
    polyn_grade  = GW'(4);
    polyn_red_in = 11'h013;
    reduc_in     = 20'h00010;
    in_valid     = 1'b1;
    bad = 0;
    lat = 0;
    @(negedge clk);
    while (!out_valid && lat < 40) begin
      if (in_ready !== 1'b0) bad++;
      @(negedge clk);
      lat++;
    end
    if (in_ready !== 1'b0) bad++;
    checks++;
    if (lat !== 4 || out !== 10'h006) begin
      errors++;
      $display("FAIL b2b_first lat=%0d out=%h required 4 006", lat, out);
    end
    handshake();
    @(negedge clk);
    checks++;
    if (bad !== 0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_ready busy_ready_cycles=%0d in_ready=%0b out_valid=%0b required 0 1 0",
               bad, in_ready, out_valid);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    gap = 0;
    @(negedge clk);
    while (!out_valid && gap < 40) begin
      @(negedge clk);
      gap++;
    end
    checks++;
    if (gap !== 4 || out !== 10'h003 || grade_err !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second lat=%0d out=%h err=%0b required 4 003 0", gap, out, grade_err);
    end
    handshake();
  endtask

  task automatic test_bad_grade();
    int g [4] = '{1, 11, 0, 31};
    int lat, bad;
    for (int k = 0; k < 4; k++) begin
      send(g[k], (N+1)'($urandom), (2*N)'($urandom));
      wait_out(lat);
      checks++;
      if (lat !== 0 || out !== '0 || grade_err !== 1'b1) begin
        errors++;
        $display("FAIL badgrade%0d lat=%0d out=%h err=%0b required 0 000 1", g[k], lat, out, grade_err);
      end
      bad = 0;
      repeat (5) begin
        @(negedge clk);
        if (out_valid !== 1'b1 || out !== '0 || grade_err !== 1'b1 || in_ready !== 1'b0) bad++;
      end
      checks++;
      if (bad !== 0) begin
        errors++;
        $display("FAIL badgrade%0d_hold unstable_cycles=%0d required 0", g[k], bad);
      end
      handshake();
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL badgrade%0d_release out_valid=%0b in_ready=%0b required 0 1", g[k], out_valid, in_ready);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    int lat, bad;
    send(8, 11'h11B, 20'h02B79);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out !== '0) begin
      errors++;
      $display("FAIL midrst_state in_ready=%0b out_valid=%0b out=%h required 1 0 000", in_ready, out_valid, out);
    end
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL midrst_no_output valid_cycles=%0d required 0", bad);
    end
    send(4, 11'h013, 20'h00010);
    wait_out(lat);
    checks++;
    if (lat !== 4 || out !== 10'h003 || grade_err !== 1'b0) begin
      errors++;
      $display("FAIL midrst_next lat=%0d out=%h err=%0b required 4 003 0", lat, out, grade_err);
    end
    handshake();
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_bad_grade();
    test_random();
    test_back_to_back();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
